alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 8-bit clocked ALU.
- Same 3-bit op select and carry-in semantics, generalised to WIDTH bits.
- Adds a valid/ready handshake on both sides, 2-deep buffering with backpressure, an internal accumulator usable as the A operand, and registered status flags (zero, negative, signed overflow, carry).
- Sits between an operand-issuing controller and a result consumer in the lab datapath.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_pipe_core.sv | 50 +++++
 rtl/alu_pipe.sv | 109 ++++++++++
 tb/tb_alu_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and encodings for the pipelined ALU: select width, addend modes,
// logic-op codes and the status-flag bundle carried alongside each result.
package alu_pkg;

  localparam int SEL_W = 3;

  // Addend chosen by sel[1:0] when sel[2]=0
  localparam logic [1:0] ADD_ZERO = 2'd0;
  localparam logic [1:0] ADD_B    = 2'd1;
  localparam logic [1:0] ADD_NOTB = 2'd2;
  localparam logic [1:0] ADD_ONES = 2'd3;

  // Logic op chosen by {sel[0], cin} when sel[2]=1
  localparam logic [1:0] LOG_AND  = 2'd0;
  localparam logic [1:0] LOG_OR   = 2'd1;
  localparam logic [1:0] LOG_XOR  = 2'd2;
  localparam logic [1:0] LOG_NOTA = 2'd3;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: maps an A operand, b, cin and sel to a WIDTH-bit
// result plus carry, signed-overflow, zero and negative flags.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] res,
  output alu_flags_t       flags
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // NOTE: every output gets a default first so no path through the case
  // statements leaves a signal unassigned, which would infer a latch.
  always_comb begin
    addend = '0;
    sum    = '0;
    res    = '0;
    flags  = '0;
    if (!sel[2]) begin
      case (sel[1:0])
        ADD_ZERO: addend = '0;
        ADD_B:    addend = op_b;
        ADD_NOTB: addend = ~op_b;
        default:  addend = '1;
      endcase
      sum        = {1'b0, op_a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
      res        = sum[WIDTH-1:0];
      flags.cout = sum[WIDTH];
      flags.ovf  = (op_a[WIDTH-1] == addend[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
    end else begin
      // sel[1] is a don't-care for logic ops; cin picks within the pair
      case ({sel[0], cin})
        LOG_AND: res = op_a & op_b;
        LOG_OR:  res = op_a | op_b;
        LOG_XOR: res = op_a ^ op_b;
        default: res = ~op_a;
      endcase
    end
    flags.zero = (res == '0);
    flags.neg  = res[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 registers operands, S2 registers the result and
// flags; an accumulator tracks the last S2 result and can replace operand A.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [SEL_W-1:0] sel,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [SEL_W-1:0] s1_sel;
  logic             s1_acc_en;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;
  alu_flags_t       flags_q;

  logic s2_adv;
  logic s1_adv;
  logic in_xfer;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  // Combinational from out_ready so a full pipe still streams at one op/cycle
  assign in_ready = !s1_valid || s2_adv;
  assign in_xfer  = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: the S1 payload has no reset; s1_valid alone qualifies it, so the
  // operand flops stay cheap and reset fanout stays on control bits.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_a      <= a;
      s1_b      <= b;
      s1_cin    <= cin;
      s1_sel    <= sel;
      s1_acc_en <= acc_en;
    end
  end

  assign op_a = s1_acc_en ? acc : s1_a;

  alu_pipe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_a  (op_a),
    .op_b  (s1_b),
    .cin   (s1_cin),
    .sel   (s1_sel),
    .res   (core_res),
    .flags (core_flags)
  );

  // acc follows every S2 load so a dependent op right behind sees it without a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data      <= '0;
      flags_q   <= '0;
      acc       <= ACC_RESET;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data    <= core_res;
        flags_q <= core_flags;
        acc     <= core_res;
      end
    end
  end

  assign cout = flags_q.cout;
  assign zero = flags_q.zero;
  assign neg  = flags_q.neg;
  assign ovf  = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed scenarios plus random
// traffic scored against an arithmetic reference model and an in-order queue.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [2:0]   sel;
  logic         acc_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data;
  logic         cout;
  logic         zero;
  logic         neg;
  logic         ovf;

  alu_pipe #(
    .WIDTH     (W),
    .ACC_RESET (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sel       (sel),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data      (data),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model_acc = 8'h00;
  int           n_out = 0;

  // Reference: unsigned sum for carry, signed sum for overflow
  function automatic exp_t ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic c, input logic [2:0] s);
    exp_t r;
    int   ud, sum, sa, sd, ss;
    r = '{default: '0};
    if (!s[2]) begin
      case (s[1:0])
        2'd0:    ud = 0;
        2'd1:    ud = int'(bv);
        2'd2:    ud = 255 - int'(bv);
        default: ud = 255;
      endcase
      sum    = int'(av) + ud + int'(c);
      r.data = sum[7:0];
      r.cout = (sum > 255);
      sa     = (av > 127) ? int'(av) - 256 : int'(av);
      sd     = (ud > 127) ? ud - 256 : ud;
      ss     = sa + sd + int'(c);
      r.ovf  = (ss > 127) || (ss < -128);
    end else begin
      case ({s[0], c})
        2'd0:    r.data = av & bv;
        2'd1:    r.data = av | bv;
        2'd2:    r.data = av ^ bv;
        default: r.data = ~av;
      endcase
    end
    r.zero = (r.data == 0);
    r.neg  = r.data[7];
    return r;
  endfunction

  logic         held = 1'b0;
  logic [W-1:0] held_data;
  logic [3:0]   held_flags;

  // Scoreboard monitor: samples on the falling edge, pops before pushing
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        check("hold_data", data, held_data);
        check("hold_flags", {cout, zero, neg, ovf}, held_flags);
      end
      held       = out_valid && !out_ready;
      held_data  = data;
      held_flags = {cout, zero, neg, ovf};
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_data", data, e.data);
          check("sb_flags", {cout, zero, neg, ovf}, {e.cout, e.zero, e.neg, e.ovf});
        end
      end
      if (in_valid && in_ready) begin
        exp_t r;
        r = ref_op(acc_en ? model_acc : a, b, cin, sel);
        model_acc = r.data;
        exp_q.push_back(r);
      end
    end
  end

  // All tasks start and end at posedge+#1
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                      input logic [2:0] s, input logic ae);
    int   k;
    logic took;
    k = 0;
    took = 1'b0;
    a = av; b = bv; cin = c; sel = s; acc_en = ae; in_valid = 1'b1;
    while (!took && k < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    if (!took) check("send_timeout", 0, 1);
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] d, input logic co,
                            input logic z, input logic n, input logic o, output int waited);
    int k;
    k = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    waited = k;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, data, d);
    check({tag, "_flags"}, {cout, zero, neg, ovf}, {co, z, n, o});
    @(posedge clk); #1;
  endtask

  task automatic set_beat(input int i);
    a = 8'(8'h10 + i); b = 8'h01; cin = 1'b0; sel = 3'b001; acc_en = 1'b0;
    in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    check("watchdog", 0, 1);
    $fatal(1, "bench timed out");
  end

  initial begin
    int   w;
    int   idx;
    int   k;
    int   n0;
    int   sent;
    logic took;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sel = '0;
    acc_en = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_data", data, 0);
    check("rst_flags", {cout, zero, neg, ovf}, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Signed overflow on add, with two-edge latency
    send(8'h7F, 8'h01, 1'b0, 3'b001, 1'b0);
    @(negedge clk);
    check("lat_early", out_valid, 0);
    expect_out("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, w);
    check("lat_cycles", w, 0);

    send(8'h05, 8'h05, 1'b1, 3'b010, 1'b0);
    expect_out("sub_eq", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, w);
    send(8'h00, 8'h00, 1'b0, 3'b011, 1'b0);
    expect_out("add_ones", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, w);

    send(8'hF0, 8'h3C, 1'b0, 3'b100, 1'b0);
    expect_out("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, w);
    send(8'hF0, 8'h3C, 1'b1, 3'b100, 1'b0);
    expect_out("or", 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0, w);
    send(8'hF0, 8'h3C, 1'b0, 3'b101, 1'b0);
    expect_out("xor", 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0, w);
    send(8'hF0, 8'h3C, 1'b1, 3'b101, 1'b0);
    expect_out("nota", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, w);
    send(8'hF0, 8'h3C, 1'b0, 3'b110, 1'b0);
    expect_out("and_alias", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, w);

    // Reset with two ops in flight (S2 and S1 both full)
    out_ready = 1'b0;
    send(8'h21, 8'h01, 1'b0, 3'b001, 1'b0);
    send(8'h40, 8'h02, 1'b0, 3'b001, 1'b0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_acc = 8'h00;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_flags", {cout, zero, neg, ovf}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(8'h55, 8'h00, 1'b0, 3'b001, 1'b1);
    expect_out("acc_after_rst", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, w);

    // Dependent accumulator chain, back to back
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          a = 8'hAA; b = 8'h03; cin = 1'b0; sel = 3'b001; acc_en = 1'b1; in_valid = 1'b1;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        int kk;
        kk = 0;
        @(negedge clk);
        while (!out_valid && kk < 20) begin
          @(negedge clk);
          kk++;
        end
        for (int i = 0; i < 3; i++) begin
          check("chain_valid", out_valid, 1);
          check("chain_data", data, 8'(3 * (i + 1)));
          @(negedge clk);
        end
      end
    join
    @(posedge clk); #1;

    // Backpressure: only two beats fit while out_ready is low
    out_ready = 1'b0;
    idx = 0;
    set_beat(0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 4) set_beat(idx); else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("bp_accepted", idx, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_hold_first", data, 8'h11);
    n0 = n_out;
    @(posedge clk); #1;
    out_ready = 1'b1;
    k = 0;
    while (idx < 4 && k < 20) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 4) set_beat(idx); else in_valid = 1'b0;
      end
      k++;
    end
    repeat (6) @(negedge clk);
    check("bp_out_count", n_out - n0, 4);
    check("bp_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // Random traffic with random backpressure
    sent = 0;
    in_valid = 1'b0;
    while (sent < 400) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) sent++;
      if (took || !in_valid) begin
        a        = 8'($urandom);
        b        = 8'($urandom);
        cin      = 1'($urandom);
        sel      = 3'($urandom);
        acc_en   = 1'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
